// File: rtl/pc_gen.sv
// Fetch PC register with next-PC selection, stall hold and buffered redirect.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHK_EN.
module pc_gen #(
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          OFF_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [3:0]  npc_instr,
  input  logic        zero,
  input  logic        negative,
  input  logic [31:0] br_pc,
  input  logic [25:0] imm,
  input  logic [31:0] rs,
  input  logic [31:0] epc,
  input  logic        int_req,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        pc_valid,
  output logic        redirect,
  output logic        adel
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      state, state_next;
  logic [31:0] pend_pc, pend_next, pc_next;
  logic [31:0] br_off, target, load_raw, load_addr;
  logic        taken, nonseq, misaligned;
  logic        redirect_next, adel_next;

  assign pc4    = pc + 32'd4;
  assign br_off = {{16{imm[15]}}, imm[15:0]} << OFF_SHIFT;

  always_comb begin
    taken = 1'b0;
    case (npc_instr)
      4'd1:    taken = zero;
      4'd2:    taken = !zero;
      4'd3:    taken = !negative && !zero;
      4'd4:    taken = !negative;
      4'd5:    taken = negative;
      4'd6:    taken = negative || zero;
      default: taken = 1'b0;
    endcase

    nonseq = 1'b1;
    target = pc4;
    if (int_req || npc_instr == 4'd9)
      target = EXC_VEC;
    else if (npc_instr == 4'd10)
      target = epc;
    else if (taken)
      target = br_pc + br_off;
    else if (npc_instr == 4'd7)
      target = {br_pc[31:28], imm, 2'b00};
    else if (npc_instr == 4'd8)
      target = rs;
    else
      nonseq = 1'b0;
  end

  // A buffered target is released from PEND; a concurrent interrupt still wins.
  always_comb begin
    load_raw = (state == PEND) ? (int_req ? EXC_VEC : pend_pc) : target;
`ifdef PC_ALIGN_CHK_EN
    misaligned = (load_raw[1:0] != 2'b00) && ((state == PEND) || nonseq);
`else
    misaligned = 1'b0;
`endif
    load_addr = misaligned ? EXC_VEC : load_raw;
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    pend_next     = pend_pc;
    redirect_next = 1'b0;
    adel_next     = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (!stall) begin
          pc_next       = load_addr;
          redirect_next = nonseq;
          adel_next     = misaligned;
        end else if (nonseq) begin
          pend_next  = target;
          state_next = PEND;
        end
      end
      PEND: begin
        if (stall) begin
          if (int_req)
            pend_next = EXC_VEC;
        end else begin
          pc_next       = load_addr;
          redirect_next = 1'b1;
          adel_next     = misaligned;
          state_next    = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      pend_pc  <= 32'd0;
      pc_valid <= 1'b0;
      redirect <= 1'b0;
      adel     <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      pend_pc  <= pend_next;
      pc_valid <= 1'b1;
      redirect <= redirect_next;
      adel     <= adel_next;
    end
  end

endmodule
